dram_controller_banked: RTL and testbench

//  68000-bus DRAM controller: multi-bank successor to the single-bank controller, with CAS-before-RAS refresh.

---
 rtl/dram_ctrl_pkg.sv | 35 +++
 rtl/dram_refresh_timer.sv | 49 ++++
 rtl/dram_controller_banked.sv | 195 +++++++++++++++++++
 tb/tb_dram_controller_banked.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the banked 68000 DRAM controller: FSM state
// encoding, strobe levels, counter width and address-mux sizing helpers.
package dram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROW     = 3'd1,
        ST_COL     = 3'd2,
        ST_CAS     = 3'd3,
        ST_HOLD    = 3'd4,
        ST_PRE     = 3'd5,
        ST_REF_CAS = 3'd6,
        ST_REF_RAS = 3'd7
    } dram_state_e;

    // All DRAM-side strobes are active low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    // Width of the shared cycle counter used for CAS wait, refresh RAS
    // low time and precharge.
    localparam int CNT_W = 8;

    // Row/column bus is as wide as the wider of the two fields.
    function automatic int mux_width(input int row_bits, input int col_bits);
        return (row_bits > col_bits) ? row_bits : col_bits;
    endfunction

    // Bank register width; kept at least 1 bit so a single-bank build
    // still has a legal vector.
    function automatic int bank_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval counter plus a 2-bit saturating refresh-debt counter.
// pending_o also covers the wrap cycle itself so an access arriving on the
// same edge as a new refresh request does not jump ahead of it.
module dram_refresh_timer #(
    parameter int REFRESH_CYCLES = 250
) (
    input  logic CLK_ALT,
    input  logic RST,
    input  logic done_i,
    output logic pending_o
);

    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    debt_q, debt_d;
    logic          wrap;

    assign wrap      = (tick_q == TW'(REFRESH_CYCLES - 1));
    assign pending_o = (debt_q != 2'd0) || wrap;

    // Next-state: free-running interval count, debt up on wrap and down on
    // completion; simultaneous wrap and completion cancel out.
    always_comb begin
        tick_d = wrap ? '0 : tick_q + TW'(1);
        debt_d = debt_q;
        if (wrap && !done_i) begin
            if (debt_q != 2'd3) begin
                debt_d = debt_q + 2'd1;
            end
        end else if (done_i && !wrap) begin
            if (debt_q != 2'd0) begin
                debt_d = debt_q - 2'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK_ALT or negedge RST) begin
        if (!RST) begin
            tick_q <= '0;
            debt_q <= 2'd0;
        end else begin
            tick_q <= tick_d;
            debt_q <= debt_d;
        end
    end

endmodule

// File: rtl/dram_controller_banked.sv
// Multi-bank 68000 DRAM controller with CAS-before-RAS refresh. One RAS per
// bank, shared byte-lane CAS strobes, write enable and DTACK, all driven
// straight from registers so the DRAM sees glitch-free strobes.
module dram_controller_banked
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 23,
    parameter int ROW_BITS       = 11,
    parameter int COL_BITS       = 11,
    parameter int NUM_BANKS      = 2,
    parameter int REFRESH_CYCLES = 250,
    parameter int CAS_WAIT       = 0,
    parameter int REF_RAS_CYCLES = 3,
    parameter int PRE_CYCLES     = 2
) (
    input  logic                                      CLK_ALT,
    input  logic                                      RST,
    input  logic                                      CS,
    input  logic                                      AS,
    input  logic                                      UDS,
    input  logic                                      LDS,
    input  logic                                      RW,
    input  logic [ADDR_W:1]                           ADDR_IN,
    output logic [mux_width(ROW_BITS, COL_BITS)-1:0]  ADDR_OUT,
    output logic [NUM_BANKS-1:0]                      RAS,
    output logic                                      CASU,
    output logic                                      CASL,
    output logic                                      WE,
    output logic                                      DTACK_DRAM
);

    localparam int MUX_W     = mux_width(ROW_BITS, COL_BITS);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = bank_width(NUM_BANKS);
    // The IDLE clock after PRE is itself a strobes-high clock, so the PRE
    // state only needs to cover the remaining PRE_CYCLES-1 clocks.
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PRE_CYCLES >= 2) ? PRE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'((REF_RAS_CYCLES >= 1) ? REF_RAS_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_WAIT);

    dram_state_e         state_q;
    logic [MUX_W-1:0]    addr_q;
    logic [NUM_BANKS-1:0] ras_q;
    logic                casu_q, casl_q, we_q, dtack_q, rw_q;
    logic [BANK_W-1:0]   bank_q;
    logic [COL_BITS-1:0] col_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [BANK_W-1:0]    bank_dec;
    logic [ROW_BITS-1:0]  row_dec;
    logic [COL_BITS-1:0]  col_dec;
    logic [NUM_BANKS-1:0] bank_sel;
    logic                 ref_pending, ref_done, release_now;
    logic                 unused_addr;

    // Address decode: column lowest, then row, then bank; upper bits unused.
    assign col_dec     = ADDR_IN[COL_BITS:1];
    assign row_dec     = ADDR_IN[COL_BITS+ROW_BITS:COL_BITS+1];
    assign unused_addr = ^ADDR_IN;

    if (BANK_BITS > 0) begin : g_bank
        assign bank_dec = ADDR_IN[COL_BITS+ROW_BITS+BANK_BITS:COL_BITS+ROW_BITS+1];
    end else begin : g_nobank
        assign bank_dec = '0;
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_sel
        assign bank_sel[gi] = (bank_q == BANK_W'(gi));
    end

    // AS going away ends any CPU cycle: before DTACK it is an abort, in
    // HOLD it is the normal end of the cycle. Both release every strobe.
    assign release_now = AS && ((state_q == ST_ROW) || (state_q == ST_COL) ||
                                (state_q == ST_CAS) || (state_q == ST_HOLD));

    assign ref_done = (state_q == ST_REF_RAS) && (cnt_q == REF_LAST);

    dram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .CLK_ALT  (CLK_ALT),
        .RST      (RST),
        .done_i   (ref_done),
        .pending_o(ref_pending)
    );

    // Main controller FSM with registered strobes and address mux.
    always_ff @(posedge CLK_ALT or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ras_q   <= '1;
            casu_q  <= STROBE_OFF;
            casl_q  <= STROBE_OFF;
            we_q    <= STROBE_OFF;
            dtack_q <= STROBE_OFF;
            rw_q    <= 1'b1;
            bank_q  <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else if (release_now) begin
            ras_q   <= '1;
            casu_q  <= STROBE_OFF;
            casl_q  <= STROBE_OFF;
            we_q    <= STROBE_OFF;
            dtack_q <= STROBE_OFF;
            cnt_q   <= '0;
            state_q <= ST_PRE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ref_pending) begin
                        casu_q  <= STROBE_ON;
                        casl_q  <= STROBE_ON;
                        state_q <= ST_REF_CAS;
                    end else if (!CS && !AS) begin
                        bank_q  <= bank_dec;
                        col_q   <= col_dec;
                        rw_q    <= RW;
                        addr_q  <= MUX_W'(row_dec);
                        state_q <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    ras_q   <= ~bank_sel;
                    state_q <= ST_COL;
                end
                ST_COL: begin
                    addr_q  <= MUX_W'(col_q);
                    we_q    <= rw_q;
                    cnt_q   <= '0;
                    state_q <= ST_CAS;
                end
                ST_CAS: begin
                    if (casu_q && casl_q) begin
                        // On writes the 68000 drives the data strobes a
                        // clock late; no lane is strobed until one shows up.
                        if (!(UDS && LDS)) begin
                            casu_q <= UDS;
                            casl_q <= LDS;
                            if (CAS_WAIT == 0) begin
                                dtack_q <= STROBE_ON;
                                state_q <= ST_HOLD;
                            end else begin
                                cnt_q <= CNT_W'(1);
                            end
                        end
                    end else if (cnt_q >= CAS_LAST) begin
                        dtack_q <= STROBE_ON;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_HOLD;
                end
                ST_PRE: begin
                    if (cnt_q >= PRE_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_REF_CAS: begin
                    ras_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_REF_RAS;
                end
                ST_REF_RAS: begin
                    if (cnt_q == REF_LAST) begin
                        ras_q   <= '1;
                        casu_q  <= STROBE_OFF;
                        casl_q  <= STROBE_OFF;
                        cnt_q   <= '0;
                        state_q <= ST_PRE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ADDR_OUT   = addr_q;
    assign RAS        = ras_q;
    assign CASU       = casu_q;
    assign CASL       = casl_q;
    assign WE         = we_q;
    assign DTACK_DRAM = dtack_q;

endmodule

// File: tb/tb_dram_controller_banked.sv
// Directed bench for the banked DRAM controller: reads, byte writes with
// data-strobe lag, foreign chip select, abort, CBR refresh cadence, refresh
// debt saturation, refresh/access priority and asynchronous reset.
module tb_dram_controller_banked;

    logic        CLK_ALT = 1'b0;
    logic        RST = 1'b0;
    logic        CS = 1'b1, AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
    logic [23:1] ADDR_IN = '0;
    logic [10:0] ADDR_OUT;
    logic [1:0]  RAS;
    logic        CASU, CASL, WE, DTACK_DRAM;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    dram_controller_banked dut (
        .CLK_ALT   (CLK_ALT),
        .RST       (RST),
        .CS        (CS),
        .AS        (AS),
        .UDS       (UDS),
        .LDS       (LDS),
        .RW        (RW),
        .ADDR_IN   (ADDR_IN),
        .ADDR_OUT  (ADDR_OUT),
        .RAS       (RAS),
        .CASU      (CASU),
        .CASL      (CASL),
        .WE        (WE),
        .DTACK_DRAM(DTACK_DRAM)
    );

    always #5 CLK_ALT = ~CLK_ALT;

    // Count of rising edges since reset release.
    always @(posedge CLK_ALT or negedge RST) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK_ALT);
    endtask

    task automatic do_reset();
        @(negedge CLK_ALT);
        RST = 1'b0;
        CS = 1'b1; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; ADDR_IN = '0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic start_access(input logic [23:1] a, input logic rw, input logic uds, input logic lds);
        ADDR_IN = a; RW = rw; UDS = uds; LDS = lds; CS = 1'b0; AS = 1'b0;
    endtask

    task automatic end_access();
        AS = 1'b1; CS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    endtask

    initial begin
        int n_ref, early, found, t_ras, t_dtack;
        int ref_at[4];

        // ---- reset state ----
        tick();
        chk("rst_ras", RAS, 2'b11);
        chk("rst_casu", CASU, 1);
        chk("rst_casl", CASL, 1);
        chk("rst_we", WE, 1);
        chk("rst_dtack", DTACK_DRAM, 1);
        chk("rst_addr", ADDR_OUT, 0);
        tick();
        RST = 1'b1;

        // ---- 1: read word 0x09001A, bank 0 ----
        start_access(23'h09001A, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t1_e0_addr_row", ADDR_OUT, 11'h120);
        chk("t1_e0_ras", RAS, 2'b11);
        tick();
        chk("t1_e1_ras", RAS, 2'b10);
        tick();
        chk("t1_e2_addr_col", ADDR_OUT, 11'h01A);
        chk("t1_e2_we", WE, 1);
        chk("t1_e2_casl", CASL, 1);
        tick();
        chk("t1_e3_casu", CASU, 0);
        chk("t1_e3_casl", CASL, 0);
        chk("t1_e3_dtack", DTACK_DRAM, 0);
        chk("t1_e3_ras", RAS, 2'b10);
        tick();
        chk("t1_hold_dtack", DTACK_DRAM, 0);
        end_access();
        tick();
        chk("t1_rel_ras", RAS, 2'b11);
        chk("t1_rel_cas", {CASU, CASL}, 2'b11);
        chk("t1_rel_dtack", DTACK_DRAM, 1);
        chk("t1_pre_addr_hold", ADDR_OUT, 11'h01A);
        $display("[TB] read 0x120034 bank0 done");

        // ---- 2: byte write 0xA00003, bank 1, lower lane, DS lag ----
        repeat (3) tick();
        start_access(23'h500001, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t2_e0_addr_row", ADDR_OUT, 11'h200);
        tick();
        chk("t2_e1_ras", RAS, 2'b01);
        tick();
        chk("t2_e2_addr_col", ADDR_OUT, 11'h001);
        chk("t2_e2_we", WE, 0);
        tick();
        chk("t2_ds_lag_casl", CASL, 1);
        chk("t2_ds_lag_dtack", DTACK_DRAM, 1);
        LDS = 1'b0;
        tick();
        chk("t2_casl", CASL, 0);
        chk("t2_casu", CASU, 1);
        chk("t2_dtack", DTACK_DRAM, 0);
        chk("t2_we_held", WE, 0);
        end_access();
        tick();
        chk("t2_rel_all", {RAS, CASU, CASL, WE, DTACK_DRAM}, 6'b111111);
        $display("[TB] byte write 0xA00003 bank1 done");

        // ---- foreign chip select ignored ----
        repeat (3) tick();
        AS = 1'b0; CS = 1'b1;
        repeat (4) tick();
        chk("cs_hi_ras", RAS, 2'b11);
        chk("cs_hi_dtack", DTACK_DRAM, 1);
        chk("cs_hi_addr", ADDR_OUT, 11'h001);
        end_access();
        $display("[TB] foreign cycle ignored");

        // ---- 6a: abort at E2 ----
        repeat (3) tick();
        start_access(23'h09001A, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("t6_abort_e1_ras", RAS, 2'b10);
        end_access();
        tick();
        chk("t6_abort_ras", RAS, 2'b11);
        chk("t6_abort_strobes", {CASU, CASL, WE, DTACK_DRAM}, 4'b1111);
        repeat (3) tick();
        chk("t6_abort_no_dtack", DTACK_DRAM, 1);
        $display("[TB] aborted access done");

        // ---- 3: 2500 idle clocks -> 10 CBR sequences ----
        do_reset();
        n_ref = 0;
        while (cyc < 2500) begin
            tick();
            if (CASL == 1'b0) begin
                n_ref++;
                chk("t3_r0_cyc", cyc % 250, 0);
                chk("t3_r0_casu", CASU, 0);
                chk("t3_r0_ras", RAS, 2'b11);
                tick();
                chk("t3_r1_ras", RAS, 2'b00);
                chk("t3_r1_we", WE, 1);
                tick();
                chk("t3_r2_ras", RAS, 2'b00);
                tick();
                chk("t3_r3_ras", RAS, 2'b00);
                chk("t3_r3_cas", {CASU, CASL}, 2'b00);
                tick();
                chk("t3_r4_ras", RAS, 2'b11);
                chk("t3_r4_cas", {CASU, CASL}, 2'b11);
                chk("t3_r4_we", WE, 1);
            end
        end
        chk("t3_ref_count", n_ref, 10);
        $display("[TB] idle refresh run done, %0d sequences", n_ref);

        // ---- 4: access coinciding with first refresh request ----
        do_reset();
        while (cyc < 249) tick();
        start_access(23'h09001A, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t4_r0_casl", CASL, 0);
        chk("t4_r0_ras", RAS, 2'b11);
        found = 0; t_ras = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (RAS == 2'b10) begin found = 1; t_ras = cyc; end
        end
        chk("t4_ras_bank_cyc", t_ras, 257);
        found = 0; t_dtack = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (DTACK_DRAM == 1'b0) begin found = 1; t_dtack = cyc; end
            else tick();
        end
        chk("t4_dtack_cyc", t_dtack, 259);
        end_access();
        tick();
        chk("t4_rel_dtack", DTACK_DRAM, 1);
        $display("[TB] refresh-first access done");

        // ---- 5: long HOLD -> debt saturates at 3 ----
        do_reset();
        tick();
        start_access(23'h09001A, 1'b1, 1'b0, 1'b0);
        while (cyc < 1100) tick();
        chk("t5_hold_dtack", DTACK_DRAM, 0);
        chk("t5_hold_ras", RAS, 2'b10);
        end_access();
        n_ref = 0;
        for (int i = 0; i < 4; i++) ref_at[i] = 0;
        repeat (100) begin
            tick();
            if (CASL == 1'b0 && RAS == 2'b11) begin
                if (n_ref < 4) ref_at[n_ref] = cyc;
                n_ref++;
            end
        end
        chk("t5_ref_count", n_ref, 3);
        chk("t5_ref0_cyc", ref_at[0], 1103);
        chk("t5_ref1_gap", ref_at[1] - ref_at[0], 6);
        chk("t5_ref2_gap", ref_at[2] - ref_at[1], 6);
        $display("[TB] saturated debt drain done, %0d refreshes", n_ref);

        // ---- 6b: asynchronous reset during REF_RAS ----
        do_reset();
        while (cyc < 252) tick();
        chk("t6_in_ref_ras", RAS, 2'b00);
        #2;
        RST = 1'b0;
        #1;
        chk("t6_async_ras", RAS, 2'b11);
        chk("t6_async_strobes", {CASU, CASL, WE, DTACK_DRAM}, 4'b1111);
        chk("t6_async_addr", ADDR_OUT, 0);
        tick();
        RST = 1'b1;
        early = 0;
        repeat (249) begin
            tick();
            if (CASL !== 1'b1 || RAS !== 2'b11) early++;
        end
        chk("t6_no_early_ref", early, 0);
        tick();
        chk("t6_first_ref", CASL, 0);
        $display("[TB] reset during refresh done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
